elastic_stage_reg: RTL and testbench



---
 rtl/elastic_stage_reg.sv | 157 +++++++++++++++
 tb/tb_elastic_stage_reg.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : elastic_stage_reg
//  Description : Generic inter-stage pipeline register with a valid/ready
//                handshake. A 2-entry skid buffer keeps in_ready registered.
//                Flush inserts a bubble (ctrl cleared, data = BUBBLE_DATA).
//                Optional macro ELASTIC_STAGE_STATS_EN adds saturating
//                stall_cnt / flush_cnt outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module elastic_stage_reg #(
  parameter int                DATA_W      = 32,
  parameter int                CTRL_W      = 8,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef ELASTIC_STAGE_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam logic [15:0] c_sat_max = 16'hFFFF;

  // Main (output) register and skid register
  logic              r_out_valid;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [1:0]        r_occupancy;

  // Next-state values
  logic              w_out_valid_n;
  logic              w_skid_valid_n;
  logic [DATA_W-1:0] w_out_data_n;
  logic [CTRL_W-1:0] w_out_ctrl_n;
  logic              w_skid_load;
  logic              w_acc_in;
  logic              w_acc_out;

  // in_ready comes straight from a flop, so the stall path never crosses
  // the stage combinationally.
  assign in_ready  = ~r_skid_valid;
  assign w_acc_in  = in_valid & ~r_skid_valid;
  assign w_acc_out = r_out_valid & out_ready;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ctrl  = r_out_ctrl;
  assign occupancy = r_occupancy;

  // Next-state decode over the (out_valid, skid_valid) state pair
  always_comb begin
    w_out_valid_n  = r_out_valid;
    w_skid_valid_n = r_skid_valid;
    w_out_data_n   = r_out_data;
    w_out_ctrl_n   = r_out_ctrl;
    w_skid_load    = 1'b0;
    case ({r_out_valid, r_skid_valid})
      2'b00: begin
        if (w_acc_in) begin
          w_out_valid_n = 1'b1;
          w_out_data_n  = in_data;
          w_out_ctrl_n  = in_ctrl;
        end
      end
      2'b10: begin
        if (w_acc_in && w_acc_out) begin
          w_out_data_n = in_data;
          w_out_ctrl_n = in_ctrl;
        end else if (w_acc_in) begin
          w_skid_valid_n = 1'b1;
          w_skid_load    = 1'b1;
        end else if (w_acc_out) begin
          // Draining to empty presents a bubble so ctrl can never leak
          w_out_valid_n = 1'b0;
          w_out_data_n  = BUBBLE_DATA;
          w_out_ctrl_n  = '0;
        end
      end
      2'b11: begin
        if (w_acc_out) begin
          w_skid_valid_n = 1'b0;
          w_out_data_n   = r_skid_data;
          w_out_ctrl_n   = r_skid_ctrl;
        end
      end
      default: begin
        // Unreachable (skid is only filled behind a valid main entry)
      end
    endcase
  end

  // State, main register and occupancy; reset and flush both leave a bubble
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_data   <= BUBBLE_DATA;
      r_out_ctrl   <= '0;
      r_occupancy  <= 2'd0;
    end else begin
      r_out_valid  <= w_out_valid_n;
      r_skid_valid <= w_skid_valid_n;
      r_out_data   <= w_out_data_n;
      r_out_ctrl   <= w_out_ctrl_n;
      r_occupancy  <= {1'b0, w_out_valid_n} + {1'b0, w_skid_valid_n};
    end
  end

  // Skid payload; contents are meaningless while skid_valid is low
  always_ff @(posedge clk) begin
    if (w_skid_load) begin
      r_skid_data <= in_data;
      r_skid_ctrl <= in_ctrl;
    end
  end

`ifdef ELASTIC_STAGE_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // Saturating statistics; only reset clears them, flush does not
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_out_valid && !out_ready && (r_stall_cnt != c_sat_max)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (flush && (r_flush_cnt != c_sat_max)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_elastic_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elastic_stage_reg
//  Description : Self-checking bench for elastic_stage_reg. Accepted entries
//                are queued and compared in order as the DUT hands them off.
//                Stats checks are active when ELASTIC_STAGE_STATS_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_elastic_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam logic [DATA_W-1:0] c_bubble = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
`ifdef ELASTIC_STAGE_STATS_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;
`endif

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t sb[$];
  entry_t exp_e;
  int     errors = 0;
  int     checks = 0;

  elastic_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
`ifdef ELASTIC_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Record an accepted entry, then advance one full cycle (to next negedge)
  task automatic tick();
    if (!rst && !flush && in_valid && in_ready) sb.push_back({in_ctrl, in_data});
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== c_bubble) begin errors++; $display("FAIL reset_data: got %h want %h", out_data, c_bubble); end
    checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL reset_ctrl: got %h want 00", out_ctrl); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = DATA_W'(i); in_ctrl = 8'hA5;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready: cycle %0d got %b want 1", i, in_ready); end
      if (i > 1) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_gap: cycle %0d out_valid got %b want 1", i, out_valid); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL stream_extra: got %h want no output", out_data); end
        else begin
          exp_e = sb.pop_front();
          if ({out_ctrl, out_data} !== exp_e) begin errors++; $display("FAIL stream_data: got %h/%h want %h/%h", out_ctrl, out_data, exp_e.ctrl, exp_e.data); end
        end
      end
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4 && sb.size() != 0; c++) begin
      if (out_valid && out_ready) begin
        checks++;
        exp_e = sb.pop_front();
        if ({out_ctrl, out_data} !== exp_e) begin errors++; $display("FAIL stream_drain_data: got %h/%h want %h/%h", out_ctrl, out_data, exp_e.ctrl, exp_e.data); end
      end
      tick();
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL stream_drain: %0d entries never output, want 0", sb.size()); end
    checks++; if (out_valid !== 1'b0 || out_data !== c_bubble || out_ctrl !== '0) begin errors++; $display("FAIL stream_idle: got v=%b d=%h c=%h want v=0 d=%h c=00", out_valid, out_data, out_ctrl, c_bubble); end
  endtask

  task automatic test_backpressure();
    int  k;
    int  outs;
    logic acc;
    k = 10; outs = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_data = DATA_W'(k); in_ctrl = 8'h3C;
      acc = in_ready;
      tick();
      if (acc) k++;
    end
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ: got %0d want 2", occupancy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    checks++; if (k !== 12) begin errors++; $display("FAIL bp_accepted: next offer %0d want 12", k); end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd10) begin errors++; $display("FAIL bp_head: got v=%b d=%h want v=1 d=0000000a", out_valid, out_data); end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && (sb.size() != 0 || k <= 12); c++) begin
      in_valid = (k <= 12); in_data = DATA_W'(k);
      if (out_valid && out_ready) begin
        checks++; outs++;
        if (sb.size() == 0) begin errors++; $display("FAIL bp_extra: got %h want no output", out_data); end
        else begin
          exp_e = sb.pop_front();
          if ({out_ctrl, out_data} !== exp_e) begin errors++; $display("FAIL bp_data: got %h/%h want %h/%h", out_ctrl, out_data, exp_e.ctrl, exp_e.data); end
        end
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
    end
    in_valid = 1'b0;
    checks++; if (outs !== 3) begin errors++; $display("FAIL bp_count: got %0d outputs want 3", outs); end
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL bp_empty: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h5A;
    in_data = 32'd20; tick();
    in_data = 32'd21; tick();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_prefill: occ got %0d want 2", occupancy); end
    in_data = 32'd22; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0; sb.delete();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL flush_ctrl: got %h want 00", out_ctrl); end
    checks++; if (out_data !== c_bubble) begin errors++; $display("FAIL flush_data: got %h want %h", out_data, c_bubble); end
    checks++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_occ: got occ=%0d rdy=%b want occ=0 rdy=1", occupancy, in_ready); end
    // Flush in ONE with in_ready high: the offered entry must still be dropped
    in_valid = 1'b1; in_data = 32'd23; tick();
    in_data = 32'd24; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0; sb.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak: got v=%b d=%h want v=0", out_valid, out_data); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'hFF;
    in_data = 32'd30; tick();
    in_data = 32'd31; tick();
    in_data = 32'd32; rst = 1'b1; flush = 1'b1; tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; sb.delete();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== c_bubble) begin errors++; $display("FAIL rstmid_out: got v=%b c=%h d=%h want v=0 c=00 d=%h", out_valid, out_ctrl, out_data, c_bubble); end
    checks++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_occ: got occ=%0d rdy=%b want occ=0 rdy=1", occupancy, in_ready); end
`ifdef ELASTIC_STAGE_STATS_EN
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_stats: got stall=%0d flush=%0d want 0/0", stall_cnt, flush_cnt); end
`endif
  endtask

`ifdef ELASTIC_STAGE_STATS_EN
  task automatic test_stats();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'd40; in_ctrl = 8'h01; tick();
    in_valid = 1'b0;
    repeat (5) tick();
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stats_stall: got %0d want 5", stall_cnt); end
    out_ready = 1'b1;
    repeat (3) begin
      flush = 1'b1; tick();
      flush = 1'b0; tick();
    end
    sb.delete();
    checks++; if (flush_cnt !== 16'd3) begin errors++; $display("FAIL stats_flush: got %0d want 3", flush_cnt); end
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stats_stall_hold: got %0d want 5", stall_cnt); end
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'd41; tick();
    in_valid = 1'b0;
    repeat (70000) @(negedge clk);
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stats_sat: got %h want ffff", stall_cnt); end
    flush = 1'b1; tick();
    flush = 1'b0; sb.delete();
    checks++; if (stall_cnt !== 16'hFFFF || flush_cnt !== 16'd4) begin errors++; $display("FAIL stats_after_flush: got stall=%h flush=%0d want ffff/4", stall_cnt, flush_cnt); end
  endtask
`endif

  // Scenario sequence
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_reset_mid();
`ifdef ELASTIC_STAGE_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
